// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared constants and helpers for the seven-segment display path
//
// Purpose: constants shared by the scan controller and the BCD decoder.
// Contents:
//   DIGIT_W    - width of one BCD digit (also used by the decoder)
//   BLANK_CODE - nibble the decoder renders as all segments off
//   MAX_DIGITS - largest digit count the scan controller supports
//   onehot()   - one-hot digit select from a digit index
package seven_segment_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam int MAX_DIGITS = 8;

  // Result is MAX_DIGITS wide; callers cast it down to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/seven_segment_scan_tick.sv
// rtl/seven_segment_scan_tick.sv - digit dwell prescaler producing the scan step strobe
//
// Purpose: counts PRESCALE clocks per displayed digit.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   step  - high during the last clock of each dwell period (every cycle when PRESCALE = 1)
module seven_segment_scan_tick #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic step
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  // Decoded from the counter register, so step is glitch-free and a full
  // dwell period always elapses after reset release.
  assign step = (presc == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (step) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// rtl/seven_segment_scan_ctrl.sv - multi-digit BCD scan controller with frame-synchronous updates
//
// Purpose: time-multiplexes NUM_DIGITS BCD digits onto one nibble bus for the
// seven-segment decoder, with double-buffered loads and leading-zero blanking.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load       - single-cycle request to capture digits_in
//   digits_in  - packed BCD, nibble i is digit i, digit 0 rightmost
//   blank_lz   - level enable for leading-zero blanking
//   bcd        - nibble for the selected digit, BLANK_CODE when blanked
//   digit_en   - one-hot select of the displayed digit
//   frame_tick - one-cycle pulse in the first cycle of each frame
module seven_segment_scan_ctrl
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic                          blank_lz,
  output logic [DIGIT_W-1:0]            bcd,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int AW = NUM_DIGITS * DIGIT_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic          step;
  logic          boundary;
  logic [IW-1:0] idx;
  logic [AW-1:0] shadow;
  logic [AW-1:0] active;
  logic          pending;
  logic [NUM_DIGITS-1:0] blank;
  logic [DIGIT_W-1:0]    cur;

  seven_segment_scan_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step)
  );

  // Last step of the frame: the only point where the displayed value may change.
  assign boundary = step && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;

      if (step) begin
        idx <= boundary ? '0 : idx + 1'b1;
      end

      if (load) begin
        shadow <= digits_in;
      end

      if (boundary) begin
        // A load coinciding with the boundary bypasses the shadow so it shows
        // in the very next frame instead of one frame later.
        if (load) begin
          active <= digits_in;
        end else if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Blanking runs from the most significant digit down and stops at the first
  // non-zero nibble; digit 0 is never blanked so zero still shows as "0".
  always_comb begin
    logic run;
    blank = '0;
    run   = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run      = run && (active[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i] = run;
    end
  end

  assign cur      = active[idx*DIGIT_W +: DIGIT_W];
  assign bcd      = blank[idx] ? BLANK_CODE : cur;
  assign digit_en = NUM_DIGITS'(onehot(3'(idx)));

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb/tb_seven_segment_scan_ctrl.sv - directed self-checking bench for seven_segment_scan_ctrl
module tb_seven_segment_scan_ctrl;

  localparam int ND = 4;
  localparam int PS = 4;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [15:0]   digits_in;
  logic          blank_lz;
  logic [3:0]    bcd;
  logic [ND-1:0] digit_en;
  logic          frame_tick;

  int errors;
  int checks;
  int k;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .bcd       (bcd),
    .digit_en  (digit_en),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // k = number of rising edges since reset release; sampling/driving at #1 after the edge.
  task automatic go(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic pulse_load(input logic [15:0] val);
    load      = 1'b1;
    digits_in = val;
    go(k + 1);
    load      = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k     = 0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    k         = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    blank_lz  = 1'b0;

    #2;
    check("rst_digit_en", 32'(digit_en), 32'h1);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    release_reset();

    check("scan_k0_en", 32'(digit_en), 32'h1);
    check("scan_k0_ft", 32'(frame_tick), 32'h0);
    go(4);  check("scan_k4_en", 32'(digit_en), 32'h2);
    go(5);  pulse_load(16'h1234);
    go(8);  check("scan_k8_en", 32'(digit_en), 32'h4);
    check("defer_k8_bcd", 32'(bcd), 32'h0);
    go(12); check("scan_k12_en", 32'(digit_en), 32'h8);
    check("defer_k12_bcd", 32'(bcd), 32'h0);
    go(15); check("ft_k15", 32'(frame_tick), 32'h0);
    go(16); check("ft_k16", 32'(frame_tick), 32'h1);
    check("load_k16_en", 32'(digit_en), 32'h1);
    check("load_k16_bcd", 32'(bcd), 32'h4);
    go(17); check("ft_k17", 32'(frame_tick), 32'h0);
    go(20); check("load_k20_bcd", 32'(bcd), 32'h3);
    go(24); check("load_k24_bcd", 32'(bcd), 32'h2);
    go(28); check("load_k28_bcd", 32'(bcd), 32'h1);
    check("load_k28_en", 32'(digit_en), 32'h8);

    // Load on the boundary cycle, then another one cycle later.
    go(31); pulse_load(16'h5678);
    check("ft_k32", 32'(frame_tick), 32'h1);
    check("coll_k32_bcd", 32'(bcd), 32'h8);
    pulse_load(16'h9999);
    go(36); check("coll_k36_bcd", 32'(bcd), 32'h7);
    go(40); check("coll_k40_bcd", 32'(bcd), 32'h6);
    go(44); check("coll_k44_bcd", 32'(bcd), 32'h5);
    go(47); check("ft_k47", 32'(frame_tick), 32'h0);
    go(48); check("ft_k48", 32'(frame_tick), 32'h1);
    check("late_k48_bcd", 32'(bcd), 32'h9);

    // Leading-zero blanking on 0070.
    go(50); blank_lz = 1'b1; pulse_load(16'h0070);
    go(64); check("lz_d0", 32'(bcd), 32'h0);
    go(68); check("lz_d1", 32'(bcd), 32'h7);
    go(72); check("lz_d2", 32'(bcd), 32'hF);
    go(76); check("lz_d3", 32'(bcd), 32'hF);
    go(77); blank_lz = 1'b0;
    go(80); check("nolz_d0", 32'(bcd), 32'h0);
    go(84); check("nolz_d1", 32'(bcd), 32'h7);
    go(88); check("nolz_d2", 32'(bcd), 32'h0);
    go(92); check("nolz_d3", 32'(bcd), 32'h0);

    // All-zero value keeps a single "0".
    go(93); blank_lz = 1'b1; pulse_load(16'h0000);
    go(96);  check("zero_d0", 32'(bcd), 32'h0);
    go(100); check("zero_d1", 32'(bcd), 32'hF);
    go(104); check("zero_d2", 32'(bcd), 32'hF);
    go(108); check("zero_d3", 32'(bcd), 32'hF);

    // Reset mid-scan with a pending load.
    blank_lz = 1'b0;
    go(110); pulse_load(16'h1234);
    go(113); check("pre_rst_bcd", 32'(bcd), 32'h4);
    go(121); pulse_load(16'h4321);
    check("pre_rst_en", 32'(digit_en), 32'h4);
    rst_n = 1'b0;
    #1;
    check("midrst_en", 32'(digit_en), 32'h1);
    check("midrst_bcd", 32'(bcd), 32'h0);
    check("midrst_ft", 32'(frame_tick), 32'h0);
    release_reset();
    go(15); check("post_rst_ft15", 32'(frame_tick), 32'h0);
    go(16); check("post_rst_ft16", 32'(frame_tick), 32'h1);
    check("post_rst_bcd0", 32'(bcd), 32'h0);
    go(24); check("post_rst_en", 32'(digit_en), 32'h4);
    check("post_rst_bcd2", 32'(bcd), 32'h0);
    go(28); check("post_rst_bcd3", 32'(bcd), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
